// File: rtl/red_pitaya_asg_seq_pkg.sv
// -----------------------------------------------------------------------------
// red_pitaya_asg_seq_pkg
// Shared types for the ASG segment sequencer:
//   - seq_state_e : sequencer FSM state encoding (exposed on dbg_state_o)
//   - seq_desc_t  : one descriptor table entry (ofs, size, step, ncyc, last
//                   and, when ASG_SEQ_GAP_EN is defined, a 32-bit gap)
//   - SEQ_FRAC_W  : fractional bits of the channel pointer (16)
// Optional feature macro: ASG_SEQ_GAP_EN adds the GAP state and the gap field.
// Descriptor fields are sized for the largest supported buffer address width
// (SEQ_RSZ_MAX); narrower instances zero-fill the upper bits.
// -----------------------------------------------------------------------------
package red_pitaya_asg_seq_pkg;

    localparam int unsigned SEQ_FRAC_W  = 16;
    localparam int unsigned SEQ_RSZ_MAX = 16;
    localparam int unsigned SEQ_NCYC_W  = 16;
    localparam int unsigned SEQ_GAP_W   = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_TRIG = 3'd3,
        ST_RUN  = 3'd4,
        ST_NEXT = 3'd5
`ifdef ASG_SEQ_GAP_EN
        , ST_GAP = 3'd6
`endif
    } seq_state_e;

    typedef struct packed {
        logic [SEQ_RSZ_MAX-1:0]            ofs;
        logic [SEQ_RSZ_MAX-1:0]            size;
        logic [SEQ_RSZ_MAX+SEQ_FRAC_W-1:0] step;
        logic [SEQ_NCYC_W-1:0]             ncyc;
        logic                              last;
`ifdef ASG_SEQ_GAP_EN
        logic [SEQ_GAP_W-1:0]              gap;
`endif
    } seq_desc_t;

endpackage

// File: rtl/red_pitaya_asg_seq_tbl.sv
// -----------------------------------------------------------------------------
// red_pitaya_asg_seq_tbl
// NSEG-entry descriptor register file with one write port and one registered
// read port.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset; clears only the read register,
//             the table contents survive reset
//   we_i    : write strobe, waddr_i / wdata_i : write index and descriptor
//   re_i    : read enable, raddr_i : read index
//   rdata_o : registered read data, holds its value while re_i is low
// A read and a write to the same index in one cycle returns the old contents.
// Optional feature macro ASG_SEQ_GAP_EN only changes the width of seq_desc_t.
// -----------------------------------------------------------------------------
module red_pitaya_asg_seq_tbl
    import red_pitaya_asg_seq_pkg::*;
#(
    parameter  int NSEG = 8,
    localparam int IW   = $clog2(NSEG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  seq_desc_t     wdata_i,
    input  logic          re_i,
    input  logic [IW-1:0] raddr_i,
    output seq_desc_t     rdata_o
);

    seq_desc_t mem_q [NSEG];
    seq_desc_t mem_d [NSEG];
    seq_desc_t rdata_q;
    seq_desc_t rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Reads sample mem_q, so a same-cycle write is not yet visible.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[raddr_i];
        end
    end

    // Table storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/red_pitaya_asg_seq.sv
// -----------------------------------------------------------------------------
// red_pitaya_asg_seq
// Segment sequencer for one Red Pitaya ASG channel. Walks a descriptor table,
// loading each segment's offset/size/step/cycle count into the channel,
// resetting and triggering it, waiting for the channel to finish, and moving
// on to the next descriptor (optionally looping the list).
//
// Ports:
//   dac_clk_i, dac_rst_i  : clock, synchronous active-high reset
//   cfg_we_i/addr/ofs/size/step/ncyc/last : descriptor table write port
//   cfg_gap_i             : per-descriptor gap in clocks (ASG_SEQ_GAP_EN only)
//   start_i, stop_i       : start / abort pulses; loop_i : loop-list level
//   ch_active_i           : channel busy level (channel dac_do)
//   seg_ofs_o, seg_size_o : {field, 16'h0} for channel set_ofs / set_size
//   seg_step_o, seg_ncyc_o: channel set_step / set_ncyc
//   ch_rst_o, ch_trig_o   : one-cycle channel reset / software trigger
//   busy_o, done_o, seg_idx_o : status; done_o is a one-cycle pulse
//   dbg_state_o           : current FSM state (seq_state_e encoding)
//
// Optional feature macro: ASG_SEQ_GAP_EN inserts a GAP state between RUN and
// NEXT that idles max(gap,1) clocks.
//
// Handshake: there is no valid/ready pairing here; start_i/stop_i are single
// cycle requests sampled on the clock edge, ch_active_i is a level, and every
// output is registered so it changes only on the clock edge.
// -----------------------------------------------------------------------------
module red_pitaya_asg_seq
    import red_pitaya_asg_seq_pkg::*;
#(
    parameter  int RSZ  = 14,
    parameter  int NSEG = 8,
    localparam int IW   = $clog2(NSEG)
) (
    input  logic                      dac_clk_i,
    input  logic                      dac_rst_i,
    input  logic                      cfg_we_i,
    input  logic [IW-1:0]             cfg_addr_i,
    input  logic [RSZ-1:0]            cfg_ofs_i,
    input  logic [RSZ-1:0]            cfg_size_i,
    input  logic [RSZ+SEQ_FRAC_W-1:0] cfg_step_i,
    input  logic [SEQ_NCYC_W-1:0]     cfg_ncyc_i,
    input  logic                      cfg_last_i,
`ifdef ASG_SEQ_GAP_EN
    input  logic [SEQ_GAP_W-1:0]      cfg_gap_i,
`endif
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      loop_i,
    input  logic                      ch_active_i,
    output logic [RSZ+SEQ_FRAC_W-1:0] seg_ofs_o,
    output logic [RSZ+SEQ_FRAC_W-1:0] seg_size_o,
    output logic [RSZ+SEQ_FRAC_W-1:0] seg_step_o,
    output logic [SEQ_NCYC_W-1:0]     seg_ncyc_o,
    output logic                      ch_rst_o,
    output logic                      ch_trig_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [IW-1:0]             seg_idx_o,
    output logic [2:0]                dbg_state_o
);

    // ---------------------------------------------------------------------
    // Descriptor table
    // ---------------------------------------------------------------------
    seq_desc_t wr_desc;
    seq_desc_t rd_desc;
    logic      tbl_re;

    always_comb begin
        wr_desc                                = '0;
        wr_desc.ofs[RSZ-1:0]                   = cfg_ofs_i;
        wr_desc.size[RSZ-1:0]                  = cfg_size_i;
        wr_desc.step[RSZ+SEQ_FRAC_W-1:0]       = cfg_step_i;
        wr_desc.ncyc                           = cfg_ncyc_i;
        wr_desc.last                           = cfg_last_i;
`ifdef ASG_SEQ_GAP_EN
        wr_desc.gap                            = cfg_gap_i;
`endif
    end

    logic [IW-1:0] idx_q, idx_d;

    // The table read register doubles as the seg_* output register: it is
    // loaded only in LOAD, so it holds in every other state and resets to 0.
    red_pitaya_asg_seq_tbl #(
        .NSEG (NSEG)
    ) u_tbl (
        .clk_i   (dac_clk_i),
        .rst_i   (dac_rst_i),
        .we_i    (cfg_we_i),
        .waddr_i (cfg_addr_i),
        .wdata_i (wr_desc),
        .re_i    (tbl_re),
        .raddr_i (idx_q),
        .rdata_o (rd_desc)
    );

    // ---------------------------------------------------------------------
    // Sequencer FSM
    // ---------------------------------------------------------------------
    seq_state_e    state_q, state_d;
    logic          seen_q, seen_d;
    logic [IW-1:0] seg_idx_q, seg_idx_d;
    logic          ch_rst_q, ch_rst_d;
    logic          ch_trig_q, ch_trig_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef ASG_SEQ_GAP_EN
    logic [SEQ_GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`endif

    logic list_end;
    assign list_end = rd_desc.last || (idx_q == IW'(NSEG - 1));

    // Outputs are computed for the state being entered, so each pulse lines
    // up with the cycle spent in that state (ch_rst_o in ARM, ch_trig_o in
    // TRIG, done_o in the first IDLE cycle).
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        seen_d    = seen_q;
        seg_idx_d = seg_idx_q;
        ch_rst_d  = 1'b0;
        ch_trig_d = 1'b0;
        done_d    = 1'b0;
        tbl_re    = 1'b0;
`ifdef ASG_SEQ_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif

        if (stop_i && (state_q != ST_IDLE)) begin
            // Abort: park the channel with a reset pulse, never report done.
            state_d  = ST_IDLE;
            ch_rst_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !stop_i) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tbl_re    = 1'b1;
                    seg_idx_d = idx_q;
                    ch_rst_d  = 1'b1;
                    state_d   = ST_ARM;
                end
                ST_ARM: begin
                    ch_trig_d = 1'b1;
                    state_d   = ST_TRIG;
                end
                ST_TRIG: begin
                    seen_d  = 1'b0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Wait for the channel to go active and then idle again;
                    // a channel that never starts keeps us here until stop.
                    if (ch_active_i) begin
                        seen_d = 1'b1;
                    end
                    if (seen_q && !ch_active_i) begin
`ifdef ASG_SEQ_GAP_EN
                        state_d   = ST_GAP;
                        gap_cnt_d = (rd_desc.gap == '0) ? '0
                                                        : rd_desc.gap - SEQ_GAP_W'(1);
`else
                        state_d = ST_NEXT;
`endif
                    end
                end
`ifdef ASG_SEQ_GAP_EN
                ST_GAP: begin
                    // Preloaded with gap-1 so the GAP state lasts max(gap,1).
                    if (gap_cnt_q == '0) begin
                        state_d = ST_NEXT;
                    end else begin
                        gap_cnt_d = gap_cnt_q - SEQ_GAP_W'(1);
                    end
                end
`endif
                ST_NEXT: begin
                    if (list_end) begin
                        if (loop_i) begin
                            idx_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_LOAD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            seen_q    <= 1'b0;
            seg_idx_q <= '0;
            ch_rst_q  <= 1'b0;
            ch_trig_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ASG_SEQ_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            seen_q    <= seen_d;
            seg_idx_q <= seg_idx_d;
            ch_rst_q  <= ch_rst_d;
            ch_trig_q <= ch_trig_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef ASG_SEQ_GAP_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign seg_ofs_o   = {rd_desc.ofs[RSZ-1:0],  {SEQ_FRAC_W{1'b0}}};
    assign seg_size_o  = {rd_desc.size[RSZ-1:0], {SEQ_FRAC_W{1'b0}}};
    assign seg_step_o  = rd_desc.step[RSZ+SEQ_FRAC_W-1:0];
    assign seg_ncyc_o  = rd_desc.ncyc;
    assign seg_idx_o   = seg_idx_q;
    assign ch_rst_o    = ch_rst_q;
    assign ch_trig_o   = ch_trig_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dbg_state_o = state_q;

    // Upper descriptor bits beyond RSZ are always zero for this instance.
    logic unused_rd_bits;
    assign unused_rd_bits = ^rd_desc;

endmodule

// File: tb/tb_red_pitaya_asg_seq.sv
// -----------------------------------------------------------------------------
// tb_red_pitaya_asg_seq
// Directed bench for red_pitaya_asg_seq (RSZ=14, NSEG=8). Inputs change 1 time
// unit after the rising edge; outputs are sampled at the same point, so each
// tick() moves to the next clock cycle. The GAP section is compiled only when
// ASG_SEQ_GAP_EN is defined.
// -----------------------------------------------------------------------------
module tb_red_pitaya_asg_seq;

    localparam int RSZ  = 14;
    localparam int NSEG = 8;
    localparam int IW   = 3;
    localparam int SW   = RSZ + 16;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ARM  = 3'd2;
    localparam logic [2:0] S_TRIG = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_GAP  = 3'd6;

`ifdef ASG_SEQ_GAP_EN
    localparam int GAP_EXTRA = 1;
`else
    localparam int GAP_EXTRA = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          dac_rst;
    logic          cfg_we;
    logic [IW-1:0] cfg_addr;
    logic [RSZ-1:0] cfg_ofs;
    logic [RSZ-1:0] cfg_size;
    logic [SW-1:0] cfg_step;
    logic [15:0]   cfg_ncyc;
    logic          cfg_last;
    logic [31:0]   cfg_gap;
    logic          start, stop, loop_l, ch_active;
    logic [SW-1:0] seg_ofs, seg_size, seg_step;
    logic [15:0]   seg_ncyc;
    logic          ch_rst, ch_trig, busy, done;
    logic [IW-1:0] seg_idx;
    logic [2:0]    dbg_state;

    red_pitaya_asg_seq #(
        .RSZ  (RSZ),
        .NSEG (NSEG)
    ) dut (
        .dac_clk_i   (clk),
        .dac_rst_i   (dac_rst),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_ofs_i   (cfg_ofs),
        .cfg_size_i  (cfg_size),
        .cfg_step_i  (cfg_step),
        .cfg_ncyc_i  (cfg_ncyc),
        .cfg_last_i  (cfg_last),
`ifdef ASG_SEQ_GAP_EN
        .cfg_gap_i   (cfg_gap),
`endif
        .start_i     (start),
        .stop_i      (stop),
        .loop_i      (loop_l),
        .ch_active_i (ch_active),
        .seg_ofs_o   (seg_ofs),
        .seg_size_o  (seg_size),
        .seg_step_o  (seg_step),
        .seg_ncyc_o  (seg_ncyc),
        .ch_rst_o    (ch_rst),
        .ch_trig_o   (ch_trig),
        .busy_o      (busy),
        .done_o      (done),
        .seg_idx_o   (seg_idx),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] e;
    int            trig_cnt;
    int            n;
    int            gap_cycles;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_desc(input int a, input int ofs, input int size, input int step,
                              input int ncyc, input logic last, input logic [31:0] gap);
        cfg_we   = 1'b1;
        cfg_addr = IW'(a);
        cfg_ofs  = RSZ'(ofs);
        cfg_size = RSZ'(size);
        cfg_step = SW'(step);
        cfg_ncyc = 16'(ncyc);
        cfg_last = last;
        cfg_gap  = gap;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Channel model: active for 10 cycles starting at the trigger cycle.
    task automatic pulse_active();
        ch_active = 1'b1;
        repeat (10) tick();
        ch_active = 1'b0;
    endtask

    task automatic wait_trig(input string tag);
        int k;
        k = 0;
        while (ch_trig !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk({tag, " trig_seen"}, 64'(ch_trig), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        chk({tag, " done_seen"}, 64'(done), 64'd1);
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        dac_rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_ofs = '0; cfg_size = '0;
        cfg_step = '0; cfg_ncyc = '0; cfg_last = 1'b0; cfg_gap = '0;
        start = 1'b0; stop = 1'b0; loop_l = 1'b0; ch_active = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst busy",    64'(busy),      64'd0);
        chk("rst ch_rst",  64'(ch_rst),    64'd0);
        chk("rst ch_trig", 64'(ch_trig),   64'd0);
        chk("rst done",    64'(done),      64'd0);
        chk("rst seg_ofs", 64'(seg_ofs),   64'd0);
        chk("rst seg_idx", 64'(seg_idx),   64'd0);
        chk("rst state",   64'(dbg_state), 64'(S_IDLE));
        dac_rst = 1'b0;

        // Two-descriptor list, exact timing
        write_desc(0, 100, 99, 32'h10000, 1, 1'b0, 32'd0);
        write_desc(1, 200, 49, 32'h20000, 2, 1'b1, 32'd0);
        start = 1'b1; tick(); start = 1'b0;                   // cycle 1
        chk("t1 c1 state", 64'(dbg_state), 64'(S_LOAD));
        chk("t1 c1 busy",  64'(busy),      64'd1);
        chk("t1 c1 ch_rst", 64'(ch_rst),   64'd0);
        tick();                                               // cycle 2
        chk("t1 c2 ch_rst",  64'(ch_rst),  64'd1);
        chk("t1 c2 ch_trig", 64'(ch_trig), 64'd0);
        chk("t1 c2 ofs",     64'(seg_ofs), 64'd100 << 16);
        chk("t1 c2 size",    64'(seg_size), 64'd99 << 16);
        chk("t1 c2 step",    64'(seg_step), 64'h10000);
        chk("t1 c2 ncyc",    64'(seg_ncyc), 64'd1);
        chk("t1 c2 idx",     64'(seg_idx), 64'd0);
        tick();                                               // cycle 3
        chk("t1 c3 ch_trig", 64'(ch_trig), 64'd1);
        chk("t1 c3 ch_rst",  64'(ch_rst),  64'd0);
        pulse_active();
        repeat (1 + GAP_EXTRA) tick();
        chk("t1 next0", 64'(dbg_state), 64'(S_NEXT));
        tick(); tick();
        chk("t1 arm1 ch_rst", 64'(ch_rst),   64'd1);
        chk("t1 arm1 ofs",    64'(seg_ofs),  64'd200 << 16);
        chk("t1 arm1 idx",    64'(seg_idx),  64'd1);
        chk("t1 arm1 ncyc",   64'(seg_ncyc), 64'd2);
        tick();
        chk("t1 trig1", 64'(ch_trig), 64'd1);
        pulse_active();
        repeat (1 + GAP_EXTRA) tick();
        chk("t1 next1 state", 64'(dbg_state), 64'(S_NEXT));
        chk("t1 next1 done",  64'(done), 64'd0);
        chk("t1 next1 busy",  64'(busy), 64'd1);
        tick();
        chk("t1 done pulse", 64'(done), 64'd1);
        chk("t1 done busy",  64'(busy), 64'd0);
        chk("t1 done state", 64'(dbg_state), 64'(S_IDLE));
        tick();
        chk("t1 done once", 64'(done), 64'd0);
        chk("t1 ofs held",  64'(seg_ofs), 64'd200 << 16);

        // Looping three-descriptor list, then stop in RUN
        write_desc(0, 100, 10, 32'h10000, 1, 1'b0, 32'd0);
        write_desc(1, 200, 10, 32'h10000, 1, 1'b0, 32'd0);
        write_desc(2, 300, 10, 32'h10000, 1, 1'b1, 32'd0);
        loop_l = 1'b1;
        exp_q.push_back(IW'(0)); exp_q.push_back(IW'(1)); exp_q.push_back(IW'(2));
        exp_q.push_back(IW'(0)); exp_q.push_back(IW'(1));
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_trig("t2");
            e = exp_q.pop_front();
            chk("t2 idx", 64'(seg_idx), 64'(e));
            chk("t2 ofs", 64'(seg_ofs), 64'((int'(e) + 1) * 100) << 16);
            if (k < 4) pulse_active();
        end
        tick();
        chk("t2 run", 64'(dbg_state), 64'(S_RUN));
        ch_active = 1'b1; tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0; ch_active = 1'b0;
        chk("t2 stop state",  64'(dbg_state), 64'(S_IDLE));
        chk("t2 stop busy",   64'(busy),   64'd0);
        chk("t2 stop ch_rst", 64'(ch_rst), 64'd1);
        chk("t2 stop done",   64'(done),   64'd0);
        tick();
        chk("t2 stop rst once", 64'(ch_rst), 64'd0);
        chk("t2 stop no done",  64'(done),   64'd0);
        loop_l = 1'b0;

        // start and stop together, then start while busy
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("t3 both state",  64'(dbg_state), 64'(S_IDLE));
        chk("t3 both busy",   64'(busy),   64'd0);
        chk("t3 both ch_rst", 64'(ch_rst), 64'd0);
        tick();
        chk("t3 both no trig", 64'(ch_trig), 64'd0);
        start = 1'b1; tick(); tick(); start = 1'b0;
        chk("t3 busy start state", 64'(dbg_state), 64'(S_ARM));
        trig_cnt = 0;
        repeat (8) begin
            tick();
            if (ch_trig === 1'b1) trig_cnt++;
        end
        chk("t3 trig count", 64'(trig_cnt), 64'd1);
        chk("t3 idle channel waits", 64'(dbg_state), 64'(S_RUN));
        stop = 1'b1; tick(); stop = 1'b0;
        chk("t3 stop state", 64'(dbg_state), 64'(S_IDLE));
        tick();

        // Reset in RUN, table retained
        start = 1'b1; tick(); start = 1'b0; tick(); tick(); tick();
        chk("t4 run", 64'(dbg_state), 64'(S_RUN));
        ch_active = 1'b1; tick();
        dac_rst = 1'b1; tick();
        chk("t4 rst busy",    64'(busy),     64'd0);
        chk("t4 rst ch_rst",  64'(ch_rst),   64'd0);
        chk("t4 rst ch_trig", 64'(ch_trig),  64'd0);
        chk("t4 rst done",    64'(done),     64'd0);
        chk("t4 rst ofs",     64'(seg_ofs),  64'd0);
        chk("t4 rst size",    64'(seg_size), 64'd0);
        chk("t4 rst step",    64'(seg_step), 64'd0);
        chk("t4 rst ncyc",    64'(seg_ncyc), 64'd0);
        chk("t4 rst idx",     64'(seg_idx),  64'd0);
        chk("t4 rst state",   64'(dbg_state), 64'(S_IDLE));
        dac_rst = 1'b0; ch_active = 1'b0; tick();
        chk("t4 post rst ch_rst", 64'(ch_rst), 64'd0);
        chk("t4 post rst done",   64'(done),   64'd0);
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("t4 replay ofs",    64'(seg_ofs), 64'd100 << 16);
        chk("t4 replay ch_rst", 64'(ch_rst),  64'd1);
        tick();
        chk("t4 replay trig", 64'(ch_trig), 64'd1);
        stop = 1'b1; tick(); stop = 1'b0; tick();

        // Table write to the index LOAD is reading in the same cycle
        start = 1'b1; tick(); start = 1'b0;
        chk("t5 load", 64'(dbg_state), 64'(S_LOAD));
        write_desc(0, 555, 10, 32'h10000, 1, 1'b0, 32'd0);
        chk("t5 old contents", 64'(seg_ofs), 64'd100 << 16);
        stop = 1'b1; tick(); stop = 1'b0; tick();
        start = 1'b1; tick(); start = 1'b0; tick();
        chk("t5 new contents", 64'(seg_ofs), 64'd555 << 16);
        stop = 1'b1; tick(); stop = 1'b0; tick();

        // Full table without last flag: ends at NSEG-1
        for (int i = 0; i < NSEG; i++) begin
            write_desc(i, 10 * (i + 1), 7, 32'h8000, 1, 1'b0, 32'd0);
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            wait_trig("t6");
            chk("t6 idx", 64'(seg_idx), 64'(k));
            pulse_active();
        end
        wait_done("t6");

`ifdef ASG_SEQ_GAP_EN
        // GAP of 5 then GAP of 0
        write_desc(0, 100, 10, 32'h10000, 1, 1'b0, 32'd5);
        write_desc(1, 200, 10, 32'h10000, 1, 1'b1, 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        wait_trig("t7a");
        pulse_active();
        gap_cycles = 0; n = 0;
        while (dbg_state !== S_NEXT && n < 30) begin
            tick(); n++;
            if (dbg_state === S_GAP) gap_cycles++;
        end
        chk("t7 gap5 cycles", 64'(gap_cycles), 64'd5);
        chk("t7 gap5 next",   64'(dbg_state),  64'(S_NEXT));
        wait_trig("t7b");
        pulse_active();
        gap_cycles = 0; n = 0;
        while (dbg_state !== S_NEXT && n < 30) begin
            tick(); n++;
            if (dbg_state === S_GAP) gap_cycles++;
        end
        chk("t7 gap0 cycles", 64'(gap_cycles), 64'd1);
        wait_done("t7");
`endif

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

endmodule
